// File: rtl/mdu_iterative_if.sv
// Request/result bundle between the core controller and the iterative MDU.
// The controller owns start/op/operands; the MDU owns status and the HI/LO values.
interface mdu_iterative_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            busy_o;
    logic            done_o;
    logic            div0_o;
    logic [XLEN-1:0] hi_o;
    logic [XLEN-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i,
        input  busy_o, done_o, div0_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i,
        output busy_o, done_o, div0_o, hi_o, lo_o
    );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per clock, XLEN steps per operation.
module mdu_iterative #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mdu_iterative_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_t;

    state_t state, state_next;

    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc;      // upper half: partial product / remainder
    logic [XLEN-1:0]   opnd;     // multiplicand / divisor magnitude
    logic [XLEN-1:0]   a_q;      // raw dividend, returned in HI on divide by zero
    logic              is_div, sign_a, sign_b, b_zero;
    logic [XLEN-1:0]   hi_q, lo_q;
    logic              done_q, div0_q;

    logic              start_arith;
    logic              op_signed, a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;

    // Only the four arithmetic ops leave IDLE; MTHI/MTLO complete in place.
    assign start_arith = (state == IDLE) && bus.start_i && (bus.op_i[2] == 1'b0);
    assign op_signed   = ~bus.op_i[0];
    assign a_neg       = op_signed & bus.a_i[XLEN-1];
    assign b_neg       = op_signed & bus.b_i[XLEN-1];
    assign mag_a       = a_neg ? -bus.a_i : bus.a_i;
    assign mag_b       = b_neg ? -bus.b_i : bus.b_i;

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= IDLE;
        else       state <= state_next;
    end

    // ---------------- next-state logic ----------------
    // NOTE: the default assignment ahead of the case keeps this purely
    // combinational; any path that missed an assignment would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_arith) state_next = CALC;
            CALC:    if (count == LAST) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM outputs ----------------
    always_comb begin
        bus.busy_o = (state != IDLE);
    end

    // ---------------- one iteration step ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        // Multiply: add multiplicand when the low multiplier bit is set, then shift right.
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};

        // Divide: shift in the next dividend bit, subtract when it fits.
        // The remainder is always below the divisor, so XLEN bits hold the difference.
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_ge    = (div_shift >= {1'b0, opnd});
        div_rem   = div_ge ? (div_shift[XLEN-1:0] - opnd) : div_shift[XLEN-1:0];
        div_next  = {div_rem, acc[XLEN-2:0], div_ge};
    end

    // ---------------- sign correction / result selection ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   res_hi, res_lo;

    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        quo_fix  = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

        res_hi = prod_fix[2*XLEN-1:XLEN];
        res_lo = prod_fix[XLEN-1:0];
        if (is_div) begin
            if (b_zero) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            count  <= '0;
            acc    <= '0;
            opnd   <= '0;
            a_q    <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            div0_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_arith) begin
                        // Both multiply and divide start with a's magnitude in the low half.
                        acc    <= {{XLEN{1'b0}}, mag_a};
                        opnd   <= mag_b;
                        a_q    <= bus.a_i;
                        is_div <= bus.op_i[1];
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        b_zero <= (bus.b_i == '0);
                        count  <= '0;
                    end else if (bus.start_i && bus.op_i == OP_MTHI) begin
                        hi_q <= bus.a_i;
                    end else if (bus.start_i && bus.op_i == OP_MTLO) begin
                        lo_q <= bus.a_i;
                    end
                end
                CALC: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + 1'b1;
                end
                FIN: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                    div0_q <= is_div & b_zero;
                end
                default: ;
            endcase
        end
    end

    assign bus.done_o = done_q;
    assign bus.div0_o = div0_q;
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// Directed-vector bench for mdu_iterative: latency, sign rules, div0, MTHI/MTLO,
// busy-time start rejection, back-to-back issue and mid-operation reset.
module tb_mdu_iterative;
    localparam int XLEN = 32;

    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;

    logic clk;
    logic rst_n;

    mdu_iterative_if #(.XLEN(XLEN)) bus ();

    mdu_iterative #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Returns at the falling edge right after the start-sampling edge E0.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.a_i     = $urandom;
        bus.b_i     = $urandom;
    endtask

    // Counts falling edges until done_o, bounded so a dead DUT cannot hang the run.
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = bus.busy_o ? 1 : 0;
        while (bus.done_o !== 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (bus.busy_o === 1'b1) busy_cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_div0);
        int c, bc;
        issue(op, a, b);
        wait_done(c, bc);
        check({tag, " latency"}, 64'(c), 64'd33);
        check({tag, " busy"}, 64'(bc), 64'd33);
        check({tag, " div0"}, 64'(bus.div0_o), 64'(exp_div0));
        check({tag, " hi"}, 64'(bus.hi_o), 64'(exp_hi));
        check({tag, " lo"}, 64'(bus.lo_o), 64'(exp_lo));
        @(negedge clk);
        check({tag, " done pulse"}, 64'(bus.done_o), 64'd0);
    endtask

    initial begin
        int c, bc, done_seen;

        rst_n       = 1'b1;
        bus.start_i = 1'b0;
        bus.op_i    = 3'b000;
        bus.a_i     = '0;
        bus.b_i     = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(bus.busy_o), 64'd0);
        check("reset done", 64'(bus.done_o), 64'd0);
        check("reset div0", 64'(bus.div0_o), 64'd0);
        check("reset hi", 64'(bus.hi_o), 64'd0);
        check("reset lo", 64'(bus.lo_o), 64'd0);
        rst_n = 1'b0;

        run_op("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult -3*5", MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("div -7/2",  DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("mult 7*-6", MULT,  32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
        run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0);
        run_op("div 7/-2",  DIV,   32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op("div ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("divu 5/0",  DIVU,  32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
        run_op("div -9/0",  DIV,   32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);

        // MTHI completes in place: HI updates at once, no busy, no done.
        issue(MTHI, 32'h0000_1234, 32'd0);
        check("mthi hi", 64'(bus.hi_o), 64'h1234);
        check("mthi busy", 64'(bus.busy_o), 64'd0);
        check("mthi done", 64'(bus.done_o), 64'd0);
        @(negedge clk);
        check("mthi done later", 64'(bus.done_o), 64'd0);

        // MTLO during a multiply must be dropped; HI/LO hold until FIN.
        issue(MULTU, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = MTLO;
        bus.a_i     = 32'h0000_00AA;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("busy mtlo lo hold", 64'(bus.lo_o), 64'hFFFF_FFFF);
        check("busy mtlo hi hold", 64'(bus.hi_o), 64'h1234);
        wait_done(c, bc);
        check("multu 3*4 done", 64'(bus.done_o), 64'd1);
        check("multu 3*4 lo", 64'(bus.lo_o), 64'd12);
        check("multu 3*4 hi", 64'(bus.hi_o), 64'd0);

        // Back-to-back: issue DIVU in the done_o cycle.
        bus.start_i = 1'b1;
        bus.op_i    = DIVU;
        bus.a_i     = 32'd50;
        bus.b_i     = 32'd8;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("b2b accepted", 64'(bus.busy_o), 64'd1);
        wait_done(c, bc);
        check("b2b latency", 64'(c), 64'd33);
        check("b2b lo", 64'(bus.lo_o), 64'd6);
        check("b2b hi", 64'(bus.hi_o), 64'd2);

        // Asynchronous reset mid-divide: everything clears and no done follows.
        issue(DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("midreset busy", 64'(bus.busy_o), 64'd0);
        check("midreset hi", 64'(bus.hi_o), 64'd0);
        check("midreset lo", 64'(bus.lo_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) done_seen++;
        end
        check("midreset no done", 64'(done_seen), 64'd0);
        check("midreset idle", 64'(bus.busy_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the multicycle MIPS core.
- Operands come straight from the register file read ports: rs data on a_i, rt data on b_i.
- hi_o/lo_o feed the writeback mux for MFHI/MFLO, so the result reaches the register file write port.
- The controller issues a one-cycle start_i and waits on busy_o/done_o.

Parameters:
XLEN, 32, operand width; HI and LO are each XLEN bits; iteration count = XLEN.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous, active-high (asserted = 1)
start_i  input  1  one-cycle operation request; sampled only in IDLE
op_i  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op
a_i  input  XLEN  rs value (multiplicand / dividend / MTHI-MTLO data)
b_i  input  XLEN  rt value (multiplier / divisor)
busy_o  output  1  high while state != IDLE (combinational from state)
done_o  output  1  one-cycle pulse: HI/LO just updated by MULT/MULTU/DIV/DIVU
div0_o  output  1  one-cycle pulse, coincident with done_o, when the divisor was 0
hi_o  output  XLEN  HI register
lo_o  output  XLEN  LO register

Behaviour:
- Reset (rst_n=1, async): state=IDLE, count=0, hi_o=0, lo_o=0, done_o=0, div0_o=0, busy_o=0. Reset mid-operation abandons the operation; no done_o follows.
- FSM states: IDLE, CALC, FIN.
- IDLE with start_i=1 at edge E0:
  - MULT/MULTU/DIV/DIVU: latch operands (magnitudes for signed ops; record sign of a, sign of b, op kind, b==0), clear the accumulator, count=0, go to CALC.
  - MTHI: hi_o<=a_i at E0, stay in IDLE, no done_o.
  - MTLO: lo_o<=a_i at E0, stay in IDLE, no done_o.
  - Ops 110/111: ignored.
- CALC: one iteration per edge (E1..E32) and count increments.
  - Multiply: shift-add of unsigned magnitudes into a 2*XLEN product.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - At the edge where count reaches XLEN-1 → FIN.
- FIN, at edge E33:
  - Apply sign correction and write HI/LO.
  - done_o=1 for the following cycle only; state → IDLE.
  - Total: done_o high in the cycle after E33 (33 clocks after the start-sampling edge).
- Sign rules:
  - MULT: 2*XLEN product is negated if sign(a) != sign(b); HI=upper half, LO=lower half.
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend; LO=quotient, HI=remainder.
  - MULTU/DIVU: no correction.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (any divide op): full latency is still taken; HI=a_i as latched, LO=all ones; div0_o pulses with done_o.
- start_i while busy_o=1 is ignored, including MTHI/MTLO. Operands are held internally, so a_i/b_i may change after E0.
- The done_o cycle is IDLE: a new start_i in that cycle is accepted (back-to-back issue).
- hi_o/lo_o hold their old values throughout CALC and change only at FIN or on MTHI/MTLO.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → busy_o high for 33 cycles; done_o 33 clocks after start edge; HI=0xFFFFFFFE, LO=0x00000001; div0_o=0.
- MULT a=0xFFFFFFFD (-3) b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then DIV a=0xFFFFFFF9 (-7) b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100 b=7 → LO=0x0000000E, HI=0x00000002. DIV a=0x80000000 b=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU a=5 b=0 → after 33 clocks done_o=1 and div0_o=1; HI=0x00000005, LO=0xFFFFFFFF.
- MTHI a=0x1234 → hi_o=0x1234 next cycle, busy_o and done_o stay 0.
- Start MULTU 3*4, pulse start_i with MTLO 0xAA at cycle 5 → ignored, LO ends as 12; new DIVU issued in the done_o cycle is accepted.
- Start DIVU, assert rst_n during iteration 10 → busy_o, hi_o, lo_o drop to 0 immediately, with no done_o afterwards.
